seq_divider: RTL



---
 rtl/div_pkg.sv | 7 +
 rtl/div_abs_neg.sv | 10 +
 rtl/seq_divider.sv | 109 ++++++++++
 3 files changed

// File: rtl/div_pkg.sv
// div_pkg: shared state encoding and result constants for seq_divider
package div_pkg;
    localparam int DEFAULT_WIDTH = 32;
    localparam logic [DEFAULT_WIDTH-1:0] DIV_ZERO_QUOT = '1;
    localparam logic [DEFAULT_WIDTH-1:0] SIGNED_MIN = {1'b1, {(DEFAULT_WIDTH-1){1'b0}}};
    typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;
endpackage

// File: rtl/div_abs_neg.sv
// div_abs_neg: conditional two's-complement negate (abs on entry, sign fixup on exit)
module div_abs_neg #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] a,
    input  logic             neg,
    output logic [WIDTH-1:0] y
);
    assign y = neg ? -a : a;
endmodule

// File: rtl/seq_divider.sv
// seq_divider: multi-cycle radix-2 restoring divider with RISC-V DIV/REM corner cases
// DIV_EARLY_OUT_EN: retire zero-divisor, overflow and |dividend|<|divisor| one cycle after accept
module seq_divider
    import div_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);
    state_t state, state_nx;
    logic [WIDTH-1:0] quo_q, dvs_q, rem_q, abs_dd, abs_dv, quo_fix, rem_fix;
    logic [WIDTH:0] shifted, diff;
    logic [CNT_W-1:0] cnt_q;
    logic sign_q, sign_r, dz_q, dd_neg, dv_neg, dz_in, early;

    assign dd_neg = is_signed & dividend[WIDTH-1];
    assign dv_neg = is_signed & divisor[WIDTH-1];
    assign dz_in = divisor == '0;
    assign in_ready = state == IDLE;
    assign out_valid = state == DONE;

    div_abs_neg #(.WIDTH(WIDTH)) u_abs_dd (.a(dividend), .neg(dd_neg), .y(abs_dd));
    div_abs_neg #(.WIDTH(WIDTH)) u_abs_dv (.a(divisor), .neg(dv_neg), .y(abs_dv));
    div_abs_neg #(.WIDTH(WIDTH)) u_fix_q (.a(quo_q), .neg(sign_q), .y(quo_fix));
    div_abs_neg #(.WIDTH(WIDTH)) u_fix_r (.a(rem_q), .neg(sign_r), .y(rem_fix));

    // WIDTH+1-bit shifted partial remainder keeps the trial-subtract sign exact
    assign shifted = {rem_q, quo_q[WIDTH-1]};
    assign diff = shifted - {1'b0, dvs_q};

`ifdef DIV_EARLY_OUT_EN
    logic ovf_in;
    assign ovf_in = is_signed && dividend == SIGNED_MIN && &divisor;
    assign early = dz_in || ovf_in || abs_dd < abs_dv;
`else
    assign early = 1'b0;
`endif

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (in_valid) state_nx = early ? DONE : CALC;
            CALC:    if (cnt_q == CNT_W'(WIDTH-1)) state_nx = FIXUP;
            FIXUP:   state_nx = DONE;
            DONE:    if (out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            quo_q <= '0;
            dvs_q <= '0;
            rem_q <= '0;
            cnt_q <= '0;
            sign_q <= 1'b0;
            sign_r <= 1'b0;
            dz_q <= 1'b0;
            quotient <= '0;
            remainder <= '0;
            div_by_zero <= 1'b0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: if (in_valid) begin
                    quo_q <= abs_dd;
                    dvs_q <= abs_dv;
                    rem_q <= '0;
                    cnt_q <= '0;
                    sign_q <= dd_neg ^ dv_neg;
                    sign_r <= dd_neg;
                    dz_q <= dz_in;
`ifdef DIV_EARLY_OUT_EN
                    if (early) begin
                        quotient <= dz_in ? DIV_ZERO_QUOT : ovf_in ? SIGNED_MIN : '0;
                        remainder <= ovf_in ? '0 : dividend;
                        div_by_zero <= dz_in;
                    end
`endif
                end
                CALC: begin
                    rem_q <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
                    quo_q <= {quo_q[WIDTH-2:0], ~diff[WIDTH]};
                    cnt_q <= cnt_q + 1'b1;
                end
                // a zero divisor leaves |dividend| in rem_q, so only the quotient needs overriding
                FIXUP: begin
                    quotient <= dz_q ? DIV_ZERO_QUOT : quo_fix;
                    remainder <= rem_fix;
                    div_by_zero <= dz_q;
                end
                default: ;
            endcase
        end
    end
endmodule
